// File: rtl/usb_pkg.sv
// usb_pkg: shared constants, state encoding and small helpers for the USB transmitter.
package usb_pkg;

  localparam int unsigned PID_W  = 4;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned LINE_W = 2;

  localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;
  localparam logic [PID_W-1:0] PID_DATA1 = 4'b1011;
  localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
  localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;
  localparam logic [PID_W-1:0] PID_STALL = 4'b1110;

  // Line pair encodings as {dplus, dminus}
  localparam logic [LINE_W-1:0] LINE_J   = 2'b10;
  localparam logic [LINE_W-1:0] LINE_K   = 2'b01;
  localparam logic [LINE_W-1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0]       SYNC_BYTE  = 8'h80;
  localparam logic [CRC_W-1:0] CRC16_POLY = 16'h8005;
  localparam logic [CRC_W-1:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } tx_state_e;

  function automatic logic pid_is_data(input logic [PID_W-1:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  function automatic logic pid_is_valid(input logic [PID_W-1:0] pid);
    return pid_is_data(pid) || (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
  endfunction

  // NRZI: a 0 toggles J<->K, a 1 holds the current line state
  function automatic logic [LINE_W-1:0] nrzi_next(input logic [LINE_W-1:0] line, input logic b);
    if (b) return line;
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_crc16.sv
// usb_tx_crc16: serial CRC16 (poly 0x8005, init 0xFFFF), one payload bit per enable.
module usb_tx_crc16
  import usb_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q, crc_d;

  // Shift in one bit; clear takes priority so a new packet always starts from init
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ din) ? CRC16_POLY : '0);
    end
  end

  // Remainder register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx.sv
// usb_tx: USB full-speed transmitter; SYNC, PID, payload, CRC16, EOP with bit stuffing and NRZI.
// Optional build macro USB_TX_STUFF_CNT_EN adds the stuffed_bits counter output.
module usb_tx
  import usb_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = 8,
  parameter int unsigned MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] tx_packet,
  input  logic [7:0] tx_packet_data,
  input  logic [6:0] buffer_occupancy,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_error,
`ifdef USB_TX_STUFF_CNT_EN
  output logic [7:0] stuffed_bits,
`endif
  output logic       dplus_out,
  output logic       dminus_out
);

  localparam int unsigned CYC_W = $clog2(BIT_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

  tx_state_e         state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [3:0]        idx_q, idx_d;
  logic [PID_W-1:0]  pid_q, pid_d;
  logic [6:0]        rem_q, rem_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        ones_q, ones_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              active_q, active_d;
  logic              err_q, err_d;
  logic              pop_q, pop_d;

  tx_state_e         nxt_state_c;
  logic [3:0]        nxt_idx_c;
  logic              nxt_bit_c;
  logic              bit_end_c;
  logic              crc_clr_c, crc_en_c, stuff_inc_c;
  logic [7:0]        pid_byte_c;
  logic [CRC_W-1:0]  crc_rem;

  assign pid_byte_c = {~pid_q, pid_q};
  assign bit_end_c  = (cyc_q == CYC_LAST);

  usb_tx_crc16 u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (crc_clr_c),
    .en    (crc_en_c),
    .din   (nxt_bit_c),
    .crc   (crc_rem)
  );

  // Next field position and its unstuffed bit value
  always_comb begin
    nxt_state_c = state_q;
    nxt_idx_c   = idx_q + 4'd1;
    nxt_bit_c   = 1'b1;
    case (state_q)
      ST_SYNC: if (idx_q == 4'd7) begin nxt_state_c = ST_PID; nxt_idx_c = '0; end
      ST_PID: begin
        if (idx_q == 4'd7) begin
          nxt_idx_c = '0;
          if (!pid_is_data(pid_q))  nxt_state_c = ST_EOP;
          else if (rem_q == 7'd0)   nxt_state_c = ST_CRC;
          else                      nxt_state_c = ST_DATA;
        end
      end
      ST_DATA: begin
        if (idx_q == 4'd7) begin
          nxt_idx_c = '0;
          if (rem_q <= 7'd1) nxt_state_c = ST_CRC;
        end
      end
      ST_CRC: if (idx_q == 4'd15) begin nxt_state_c = ST_EOP; nxt_idx_c = '0; end
      default: ;
    endcase
    case (nxt_state_c)
      ST_SYNC: nxt_bit_c = SYNC_BYTE[nxt_idx_c[2:0]];
      ST_PID:  nxt_bit_c = pid_byte_c[nxt_idx_c[2:0]];
      ST_DATA: nxt_bit_c = (nxt_idx_c == 4'd0) ? tx_packet_data[0] : shift_q[nxt_idx_c[2:0]];
      ST_CRC:  nxt_bit_c = ~crc_rem[4'd15 - nxt_idx_c];
      default: nxt_bit_c = 1'b1;
    endcase
  end

  // FSM next state, stuffing and NRZI line update at each bit boundary
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    idx_d       = idx_q;
    pid_d       = pid_q;
    rem_d       = rem_q;
    shift_d     = shift_q;
    ones_d      = ones_q;
    line_d      = line_q;
    active_d    = active_q;
    err_d       = 1'b0;
    pop_d       = 1'b0;
    crc_clr_c   = 1'b0;
    crc_en_c    = 1'b0;
    stuff_inc_c = 1'b0;

    if (pop_q) shift_d = tx_packet_data;
    if (state_q != ST_IDLE) cyc_d = bit_end_c ? '0 : cyc_q + CYC_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (tx_packet != 4'd0) begin
          if (pid_is_valid(tx_packet) &&
              (!pid_is_data(tx_packet) || 32'(buffer_occupancy) <= MAX_PAYLOAD)) begin
            state_d   = ST_SYNC;
            cyc_d     = '0;
            idx_d     = '0;
            pid_d     = tx_packet;
            rem_d     = buffer_occupancy;
            ones_d    = {2'b00, SYNC_BYTE[0]};
            line_d    = nrzi_next(LINE_J, SYNC_BYTE[0]);
            active_d  = 1'b1;
            crc_clr_c = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EOP: begin
        if (bit_end_c) begin
          idx_d  = idx_q + 4'd1;
          line_d = (idx_q == 4'd0) ? LINE_SE0 : LINE_J;
          if (idx_q == 4'd2) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            active_d = 1'b0;
          end
        end
      end
      default: begin
        if (bit_end_c) begin
          if (ones_q == 3'd6) begin
            ones_d      = '0;
            line_d      = nrzi_next(line_q, 1'b0);
            stuff_inc_c = 1'b1;
          end else begin
            state_d = nxt_state_c;
            idx_d   = nxt_idx_c;
            if (nxt_state_c == ST_EOP) begin
              line_d = LINE_SE0;
              ones_d = '0;
            end else begin
              line_d = nrzi_next(line_q, nxt_bit_c);
              ones_d = nxt_bit_c ? ones_q + 3'd1 : 3'd0;
              if (state_q == ST_DATA && idx_q == 4'd7 && nxt_state_c == ST_DATA) rem_d = rem_q - 7'd1;
              if (nxt_state_c == ST_DATA) begin
                crc_en_c = 1'b1;
                if (nxt_idx_c == 4'd0) pop_d = 1'b1;
              end
            end
          end
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      idx_q    <= '0;
      pid_q    <= '0;
      rem_q    <= '0;
      shift_q  <= '0;
      ones_q   <= '0;
      line_q   <= LINE_J;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      pop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      pid_q    <= pid_d;
      rem_q    <= rem_d;
      shift_q  <= shift_d;
      ones_q   <= ones_d;
      line_q   <= line_d;
      active_q <= active_d;
      err_q    <= err_d;
      pop_q    <= pop_d;
    end
  end

`ifdef USB_TX_STUFF_CNT_EN
  logic [7:0] scnt_q, scnt_d;

  // Saturating count of stuffed bits, cleared when a request is accepted
  always_comb begin
    scnt_d = scnt_q;
    if (crc_clr_c)                           scnt_d = '0;
    else if (stuff_inc_c && scnt_q != 8'hFF) scnt_d = scnt_q + 8'd1;
  end

  // Stuffed-bit counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) scnt_q <= '0;
    else        scnt_q <= scnt_d;
  end

  assign stuffed_bits = scnt_q;
`else
  logic unused_stuff_inc;
  assign unused_stuff_inc = stuff_inc_c;
`endif

  assign dplus_out          = line_q[1];
  assign dminus_out         = line_q[0];
  assign get_tx_packet_data = pop_q;
  assign tx_transfer_active = active_q;
  assign tx_error           = err_q;

endmodule
